// File: rtl/cla_pkg.sv
// Shared constants and configuration checks for the pipelined CLA adder/subtractor.
package cla_pkg;

    localparam int unsigned GRP_W      = 4;
    localparam int unsigned MIN_SEG_W  = 2;
    localparam int unsigned MAX_STAGES = 8;

    // True when the width splits into equal segments of a usable size.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= MAX_STAGES) &&
               ((width % stages) == 0) && ((width / stages) >= MIN_SEG_W);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit carry-lookahead adder.
// Built from 4-bit generate/propagate groups with a second lookahead level.
module cla_seg
    import cla_pkg::*;
#(
    parameter int unsigned SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    localparam int unsigned NG = (SEG_W + GRP_W - 1) / GRP_W;
    localparam int unsigned PW = NG * GRP_W;

    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [NG-1:0] gg;
    logic [NG-1:0] pg;
    logic [NG:0]   cg;
    logic [PW:0]   c;

    // Padding bits above SEG_W are zero, so they neither generate nor propagate.
    assign g = PW'(a & b);
    assign p = PW'(a ^ b);

    for (genvar j = 0; j < int'(NG); j++) begin : g_grp
        localparam int unsigned B = j * GRP_W;

        assign gg[j] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1]) |
                       (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign pg[j] = &p[B +: GRP_W];

        assign c[B]   = cg[j];
        assign c[B+1] = g[B] | (p[B] & cg[j]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[j]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B]) |
                        (p[B+2] & p[B+1] & p[B] & cg[j]);
    end

    // Group carries are each formed directly from cin and the group G/P terms.
    always_comb begin
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b1;
        cg  = '0;
        cg[0] = cin;
        for (int j = 1; j <= int'(NG); j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                acc = acc | (gg[i] & pp);
                pp  = pp & pg[i];
            end
            cg[j] = acc | (cin & pp);
        end
    end

    assign c[PW]  = cg[NG];
    assign s      = p[SEG_W-1:0] ^ c[SEG_W-1:0];
    assign cout   = c[SEG_W];
    assign c_msb  = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one segment per stage, carry forwarded
// between stages, with skew registers and a valid/ready handshake.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_v
);

    localparam int unsigned SEG_W = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("cla_pipe_addsub: WIDTH must split into STAGES (1..8) segments of >= 2 bits");
    end

    logic                adv_c;
    logic [STAGES-1:0]   vld_q;
    logic [STAGES-1:0]   car_q;
    logic                ov_q;
    logic [WIDTH-1:0]    d_q   [STAGES];
    logic [WIDTH-1:0]    b_q   [STAGES];

    logic [WIDTH-1:0]    a_in  [STAGES];
    logic [WIDTH-1:0]    b_in  [STAGES];
    logic [WIDTH-1:0]    d_nxt [STAGES];
    logic [STAGES-1:0]   c_in;
    logic [STAGES-1:0]   v_in;
    logic [SEG_W-1:0]    s_w   [STAGES];
    logic [STAGES-1:0]   co_w;
    logic [STAGES-1:0]   cm_w;

    assign adv_c   = ~o_valid | i_ready;
    assign o_ready = adv_c & ~i_rst;

    assign o_valid = vld_q[STAGES-1];
    assign o_s     = d_q[STAGES-1];
    assign o_c     = car_q[STAGES-1];
    assign o_v     = ov_q;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_in[k] = i_a;
            assign b_in[k] = i_sub ? ~i_b : i_b;
            assign c_in[k] = i_sub ^ i_c;
            assign v_in[k] = i_valid;
        end else begin : g_next
            assign a_in[k] = d_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = car_q[k-1];
            assign v_in[k] = vld_q[k-1];
        end

        cla_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a     (a_in[k][k*SEG_W +: SEG_W]),
            .b     (b_in[k][k*SEG_W +: SEG_W]),
            .cin   (c_in[k]),
            .s     (s_w[k]),
            .cout  (co_w[k]),
            .c_msb (cm_w[k])
        );

        // Data word: finished result segments below, untouched A segments above.
        always_comb begin
            d_nxt[k] = a_in[k];
            d_nxt[k][k*SEG_W +: SEG_W] = s_w[k];
        end

        // Data only loads on real operations so bubbles leave outputs untouched.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                vld_q[k] <= 1'b0;
                car_q[k] <= 1'b0;
                d_q[k]   <= '0;
                b_q[k]   <= '0;
            end else if (adv_c) begin
                vld_q[k] <= v_in[k];
                if (v_in[k]) begin
                    car_q[k] <= co_w[k];
                    d_q[k]   <= d_nxt[k];
                    b_q[k]   <= b_in[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_q <= 1'b0;
        end else if (adv_c && v_in[STAGES-1]) begin
            ov_q <= cm_w[STAGES-1] ^ co_w[STAGES-1];
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: randomized and directed operations checked
// against an arithmetic reference model, with backpressure and mid-stream reset.
module tb_cla_pipe_addsub;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        int               lat;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_c;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_s;
    logic             o_c;
    logic             o_v;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    bit               done;
    bit               hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_s;
    logic             hold_c;
    logic             hold_v;

    cla_pipe_addsub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c     (i_c),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_s     (o_s),
        .o_c     (o_c),
        .o_v     (o_v)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic and sign rules.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c, input logic sub);
        exp_t e;
        logic [WIDTH:0] t;
        if (!sub) begin
            t   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
            e.s = t[WIDTH-1:0];
            e.c = t[WIDTH];
            e.v = (a[WIDTH-1] == b[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
        end else begin
            e.s = a - b - WIDTH'(c);
            e.c = ({1'b0, a} >= ({1'b0, b} + (WIDTH+1)'(c)));
            e.v = (a[WIDTH-1] != b[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
        end
        e.lat = -1;
        return e;
    endfunction

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic sub, input bit chk_lat);
        exp_t e;
        bit   acc;
        acc = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_c     = c;
        i_sub   = sub;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge i_clk);
            if (o_ready) begin
                e = model(a, b, c, sub);
                e.lat = chk_lat ? cyc + int'(STAGES) : -1;
                sb.push_back(e);
                acc = 1'b1;
            end else begin
                @(posedge i_clk);
                #1;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept, expected accept within 100 cycles");
        end
    endtask

    task automatic idle();
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge i_clk);
            #2;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops one expectation per output handshake; checks stall stability.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_s", 64'(o_s), 64'(hold_s));
                chk("hold_c", 64'(o_c), 64'(hold_c));
                chk("hold_v", 64'(o_v), 64'(hold_v));
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got o_valid=1 s=0x%0h, expected no result", o_s);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 64'(o_s), 64'(e.s));
                    chk("carry", 64'(o_c), 64'(e.c));
                    chk("overflow", 64'(o_v), 64'(e.v));
                    if (e.lat >= 0) chk("latency", 64'(cyc), 64'(e.lat));
                end
            end
            hold_pend = o_valid && !i_ready;
            hold_s    = o_s;
            hold_c    = o_c;
            hold_v    = o_v;
        end
    end

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        i_c     = 1'b0;
        i_sub   = 1'b0;
        done    = 1'b0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_s", 64'(o_s), 64'd0);
        chk("rst_c", 64'(o_c), 64'd0);
        chk("rst_v", 64'(o_v), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Bubbles with garbage operands must not disturb the reset-valued outputs.
        i_a = 32'hDEADBEEF;
        i_b = 32'h12345678;
        i_c = 1'b1;
        repeat (6) @(posedge i_clk);
        @(negedge i_clk);
        chk("pre_first_s", 64'(o_s), 64'd0);
        chk("pre_first_c", 64'(o_c), 64'd0);

        // Directed boundary cases.
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
        send(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b1);
        send(32'h00000010, 32'h00000001, 1'b1, 1'b1, 1'b1);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        send(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        idle();
        drain();

        // Back-to-back mixed stream, then a full pipeline held for 3 cycles.
        for (int i = 0; i < 10; i++)
            send($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
                idle();
            end
            begin
                repeat (6) @(posedge i_clk);
                #1;
                i_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge i_clk);
                    chk("stall_ready", 64'(o_ready), 64'd0);
                    @(posedge i_clk);
                    #1;
                end
                i_ready = 1'b1;
            end
        join
        drain();

        // Random gaps on both sides of the pipeline.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(3) == 0) idle();
                    send($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge i_clk);
                    #1;
                    i_ready = 1'($urandom_range(1));
                end
                i_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight.
        send(32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1);
        send(32'h33333333, 32'h44444444, 1'b1, 1'b1, 1'b1);
        send(32'h55555555, 32'h66666666, 1'b0, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_rst   = 1'b1;
        sb.delete();
        @(negedge i_clk);
        chk("midrst_ready", 64'(o_ready), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_s", 64'(o_s), 64'd0);
        chk("midrst_c", 64'(o_c), 64'd0);
        chk("midrst_v", 64'(o_v), 64'd0);
        send(32'h0000ABCD, 32'h00001234, 1'b1, 1'b1, 1'b1);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
